// File: rtl/cpu_axi_bridge_pkg.sv
// Shared encodings, default IDs and FSM state type for the core-to-AXI bridge.
package cpu_axi_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [2:0] SIZE_B = 3'b000;
  localparam logic [2:0] SIZE_H = 3'b001;
  localparam logic [2:0] SIZE_W = 3'b010;

  localparam int unsigned DEF_ID_W    = 4;
  localparam int unsigned DEF_INST_ID = 0;
  localparam int unsigned DEF_DATA_ID = 1;

  typedef enum logic [2:0] {
    StIdle,
    StDAr,
    StDR,
    StDAw,
    StDB,
    StIAr,
    StIR
  } state_e;

  // Illegal strobe patterns fall through to byte size.
  function automatic logic [2:0] wen_to_awsize(input logic [3:0] wen);
    logic [2:0] size;
    case (wen)
      4'b1111:          size = SIZE_W;
      4'b0011, 4'b1100: size = SIZE_H;
      default:          size = SIZE_B;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI3/AXI4 single-beat master bus as seen from the bridge (master) and crossbar (slave).
interface cpu_axi_bridge_if
  import cpu_axi_bridge_pkg::*;
#(
  parameter int unsigned ID_W = DEF_ID_W
) ();

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cpu_axi_bridge_axi_wr_ch.sv
// Tracks the independent AW and W handshakes of one write; both_done fires in the cycle
// the later of the two is accepted.
module cpu_axi_bridge_axi_wr_ch (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_awready,
  input  logic i_wready,
  output logic o_awvalid,
  output logic o_wvalid,
  output logic o_both_done
);

  logic r_awvalid;
  logic r_wvalid;
  logic r_aw_done;
  logic r_w_done;
  logic w_aw_ok;
  logic w_w_ok;

  assign w_aw_ok     = r_aw_done | (r_awvalid & i_awready);
  assign w_w_ok      = r_w_done | (r_wvalid & i_wready);
  assign o_both_done = w_aw_ok & w_w_ok;
  assign o_awvalid   = r_awvalid;
  assign o_wvalid    = r_wvalid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (i_start) begin
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (o_both_done) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (r_awvalid && i_awready) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (r_wvalid && i_wready) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's SRAM-like instruction/data ports onto one single-outstanding AXI master,
// stalling the pipeline until every access requested this cycle has completed.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int unsigned ID_W    = DEF_ID_W,
  parameter int unsigned INST_ID = DEF_INST_ID,
  parameter int unsigned DATA_ID = DEF_DATA_ID
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inst_sram_en,
  input  logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_rdata,
  input  logic                   data_sram_en,
  input  logic [3:0]             data_sram_wen,
  input  logic [31:0]            data_sram_addr,
  input  logic [31:0]            data_sram_wdata,
  output logic [31:0]            data_sram_rdata,
  output logic                   stallreq_o,
  cpu_axi_bridge_if.master       axi
);

  state_e          r_state;
  logic            r_inst_done;
  logic            r_data_done;
  logic [31:0]     r_inst_rdata;
  logic [31:0]     r_data_rdata;
  logic            r_arvalid;
  logic [31:0]     r_araddr;
  logic [ID_W-1:0] r_arid;
  logic            r_rready;
  logic [31:0]     r_awaddr;
  logic [ID_W-1:0] r_awid;
  logic [2:0]      r_awsize;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic            r_bready;

  logic w_inst_pend;
  logic w_data_pend;
  logic w_wr_start;
  logic w_both_done;
  logic w_unused;

  assign w_inst_pend = inst_sram_en & ~r_inst_done;
  assign w_data_pend = data_sram_en & ~r_data_done;
  assign stallreq_o  = w_inst_pend | w_data_pend;
  assign w_wr_start  = (r_state == StIdle) & w_data_pend & (data_sram_wen != 4'b0000);

  // Response IDs/status are not needed: only one transaction is ever in flight.
  assign w_unused = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

  cpu_axi_bridge_axi_wr_ch u_wr_ch (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_wr_start),
    .i_awready   (axi.awready),
    .i_wready    (axi.wready),
    .o_awvalid   (axi.awvalid),
    .o_wvalid    (axi.wvalid),
    .o_both_done (w_both_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arid       <= '0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_awid       <= '0;
      r_awsize     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bready     <= 1'b0;
    end else begin
      if (!stallreq_o) begin
        r_inst_done <= 1'b0;
        r_data_done <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (w_data_pend) begin
            if (data_sram_wen == 4'b0000) begin
              r_state   <= StDAr;
              r_arvalid <= 1'b1;
              r_araddr  <= data_sram_addr;
              r_arid    <= ID_W'(DATA_ID);
            end else begin
              r_state  <= StDAw;
              r_awaddr <= data_sram_addr;
              r_awid   <= ID_W'(DATA_ID);
              r_awsize <= wen_to_awsize(data_sram_wen);
              r_wdata  <= data_sram_wdata;
              r_wstrb  <= data_sram_wen;
            end
          end else if (w_inst_pend) begin
            r_state   <= StIAr;
            r_arvalid <= 1'b1;
            r_araddr  <= inst_sram_addr;
            r_arid    <= ID_W'(INST_ID);
          end
        end
        StDAr, StIAr: begin
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= (r_state == StDAr) ? StDR : StIR;
          end
        end
        StDR: begin
          if (axi.rvalid) begin
            r_rready     <= 1'b0;
            r_data_rdata <= axi.rdata;
            r_data_done  <= 1'b1;
            r_state      <= StIdle;
          end
        end
        StIR: begin
          if (axi.rvalid) begin
            r_rready     <= 1'b0;
            r_inst_rdata <= axi.rdata;
            r_inst_done  <= 1'b1;
            r_state      <= StIdle;
          end
        end
        StDAw: begin
          if (w_both_done) begin
            r_bready <= 1'b1;
            r_state  <= StDB;
          end
        end
        StDB: begin
          if (axi.bvalid) begin
            r_bready    <= 1'b0;
            r_data_done <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;

  assign axi.arid    = r_arid;
  assign axi.araddr  = r_araddr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = SIZE_W;
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;
  assign axi.awid    = r_awid;
  assign axi.awaddr  = r_awaddr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = r_awsize;
  assign axi.awburst = BURST_INCR;
  assign axi.wid     = r_awid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = r_bready;

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Converts the core's SRAM-like instruction and data ports into a single AXI3/AXI4-compatible master.
- One transaction outstanding at a time; single-beat bursts only.
- Freezes the core pipeline via `stallreq_o` (wired to the core's `stallreq_from_outside`) until every access requested in the current cycle has completed.
- Sits directly between the core and the SoC AXI crossbar.

Parameters:
- ID_W, 4, AXI ID width.
- INST_ID, 0, arid used for instruction fetches.
- DATA_ID, 1, arid/awid used for data accesses.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- inst_sram_en  in  1  instruction read request
- inst_sram_addr  in  32  fetch address (word aligned)
- inst_sram_rdata  out  32  fetched word, registered
- data_sram_en  in  1  data request
- data_sram_wen  in  4  byte write strobes; 0 = read
- data_sram_addr  in  32  data address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  loaded word (full word, lane select done by core), registered
- stallreq_o  out  1  pipeline freeze request to core
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1  AXI write address
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1
- bready  out  1

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, all valid/ready outputs 0, inst_done=data_done=0, both rdata regs 0. Address/ID outputs 0.
- Reset asserted mid-transaction abandons it immediately; the interconnect is reset alongside the bridge.
- Constant fields:
  - arlen=awlen=0, arburst=awburst=INCR(01), wlast=1.
  - arsize=010 for all reads.
  - wid=awid=DATA_ID.
- awsize from wen:
  - 1111 -> 010
  - 0011 or 1100 -> 001
  - single bit set -> 000
  - other patterns are illegal; behaviour unspecified.
- wstrb=wen, awaddr=addr, wdata=data_sram_wdata, all captured at request.
- stallreq_o (combinational) = (inst_sram_en & ~inst_done) | (data_sram_en & ~data_done).
  - It goes high in the same cycle the request appears.
  - The core holds all request inputs stable while stallreq_o=1.
- inst_done/data_done clear on any cycle where stallreq_o=0; they are set on completion of their access.
- FSM states: IDLE, D_AR, D_R, D_AW, D_B, I_AR, I_R.
- From IDLE, when stallreq_o=1:
  - data pending, wen==0 -> D_AR.
  - data pending, wen!=0 -> D_AW.
  - else inst pending -> I_AR.
  - Data always has priority over inst.
- D_AR / I_AR: arvalid=1 with the captured address and matching ID; on arready go to D_R / I_R.
- D_R / I_R:
  - rready=1.
  - On rvalid (rlast assumed, rresp ignored): write rdata into the matching rdata reg, set the done flag, return to IDLE.
  - Next step is re-evaluated from IDLE on the following cycle.
- D_AW:
  - awvalid and wvalid both asserted on entry.
  - Each drops independently on its own handshake.
  - AW-before-W, W-before-AW and simultaneous acceptance are all legal.
  - Move to D_B once both have been accepted.
- D_B: bready=1; on bvalid (bresp ignored) set data_done and return to IDLE.
- AXI rules: a valid never depends combinationally on its ready, and once asserted it holds with stable payload until the handshake.
- Latency:
  - Minimum stall for a single read is 3 cycles (IDLE->AR->R->IDLE).
  - rdata is valid in the first cycle stallreq_o=0 and holds until overwritten.
- Mismatched rid/bid is not checked; the single-outstanding design guarantees the match.
- Flush has no effect; an issued AXI transaction always completes.

Decomposition:
- Shared package holds:
  - AXI encodings: BURST_INCR, SIZE_B/H/W.
  - Default IDs.
  - FSM state enum.
  - A function wen -> awsize.
- One sub-module is natural: `axi_wr_ch`, the AW/W independent-handshake tracker (inputs start, awready, wready; outputs awvalid, wvalid, both_done).

Test Plan:
- Inst fetch 0xBFC00000, arready after 2 cycles, rdata 0x3C08BFAF after 1 more -> arid=0, arsize=010, stallreq_o high exactly until the rdata cycle; inst_sram_rdata=0x3C08BFAF on the release cycle.
- Simultaneous inst 0xBFC00004 and data load 0x80001000 -> AR order: data (id 1) first, then inst (id 0); stallreq_o stays high until both complete; both rdata regs correct.
- Store byte wen=0010, addr 0x80000001, wdata 0x0000AB00 -> awsize=000, wstrb=0010, wlast=1.
  - Sub-case: wready one cycle before awready -> wvalid drops first; bready asserted only after both handshakes; data_done set on bvalid.
- Store word wen=1111 with awready and wready in the same cycle -> D_B entered next cycle; awsize=010.
- rst=0 during D_R -> next cycle all valids 0, state IDLE, stallreq_o reflects only the current en inputs with done flags cleared.
- Back-to-back fetches 0x0, 0x4, 0x8 with zero-wait slave -> each stalls 3 cycles, done flags clear between requests, no duplicate AR issued.
